// File: rtl/mov8_sequencer.sv
// mov8_sequencer: byte-move bus initiator for the MOV8 instruction.
// Drives one-hot source select (sel) and destination load (ld) with
// break-before-make ordering: sel settles, ld pulses, ld falls, then sel falls.
// Optional feature macro: MOV8_CLEAR_EN (src==dst clears the destination
// instead of being rejected).
module mov8_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned LOAD_CYCLES   = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] src,
   input  logic [2:0] dst,
   output logic [7:0] sel,
   output logic [7:0] ld,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned REG_W = 3;
   localparam int unsigned BUS_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEL,
      ST_LOAD,
      ST_HOLD,
      ST_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [REG_W-1:0]   src_q, src_d;
   logic [REG_W-1:0]   dst_q, dst_d;
   logic               clr_q, clr_d;
   logic [BUS_W-1:0]   sel_d, ld_d;
   logic               busy_d, done_d, err_d;
   logic               drive_sel_c;

   // Next-state, dwell counter, request latch and next-output decode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      src_d   = src_q;
      dst_d   = dst_q;
      clr_d   = clr_q;
      err_d   = 1'b0;
      sel_d   = '0;
      ld_d    = '0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
`ifdef MOV8_CLEAR_EN
               src_d   = src;
               dst_d   = dst;
               clr_d   = (src == dst);
               cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
               state_d = ST_SEL;
`else
               if (src == dst) begin
                  err_d = 1'b1;
               end else begin
                  src_d   = src;
                  dst_d   = dst;
                  clr_d   = 1'b0;
                  cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                  state_d = ST_SEL;
               end
`endif
            end
         end
         ST_SEL: begin
            if (cnt_q == '0) begin
               cnt_d   = CNT_W'(LOAD_CYCLES - 1);
               state_d = ST_LOAD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_LOAD: begin
            if (cnt_q == '0) begin
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_HOLD: state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Outputs are decoded from the next state so the registered copy
      // lines up with the state register cycle for cycle.
      drive_sel_c = (state_d == ST_SEL) || (state_d == ST_LOAD) || (state_d == ST_HOLD);
      if (drive_sel_c && !clr_d) begin
         sel_d = BUS_W'(1) << src_d;
      end
      if (state_d == ST_LOAD) begin
         ld_d = BUS_W'(1) << dst_d;
      end
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   // State, dwell counter and latched request
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         src_q   <= '0;
         dst_q   <= '0;
         clr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         clr_q   <= clr_d;
      end
   end

   // Registered strobes and status
   always_ff @(posedge clk) begin
      if (reset) begin
         sel  <= '0;
         ld   <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         err  <= 1'b0;
      end else begin
         sel  <= sel_d;
         ld   <= ld_d;
         busy <= busy_d;
         done <= done_d;
         err  <= err_d;
      end
   end

endmodule

// File: tb/tb_mov8_sequencer.sv
// Testbench for mov8_sequencer: timeline reference model for sel/ld/busy,
// scoreboard queue for done/err pulses, randomized plus directed requests.
module tb_mov8_sequencer;

   localparam int unsigned S = 2;
   localparam int unsigned L = 2;
   localparam int N = 4096;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [2:0] src = '0;
   logic [2:0] dst = '0;
   logic [7:0] sel, ld;
   logic       busy, done, err;

   mov8_sequencer #(.SETTLE_CYCLES(S), .LOAD_CYCLES(L)) dut (
      .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst),
      .sel(sel), .ld(ld), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Cycle c is the clock period that ends at rising edge number c.
   int edges = 0;
   always @(posedge clk) edges <= edges + 1;

   typedef struct {
      bit         is_err;
      int         cyc;
      logic [2:0] s;
      logic [2:0] d;
   } ev_t;

   ev_t        sb[$];
   logic [7:0] exp_sel [N];
   logic [7:0] exp_ld  [N];
   bit         exp_busy[N];
   int         busy_until = 0;
   int         vectors = 0;
   int         miscompares = 0;
   bit         checking = 0;
   logic [7:0] prev_sel = '0;
   int         mc;

   task automatic check(input string name, input int c, input logic [7:0] act, input logic [7:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, expv);
      end
   endtask

   // Reference model: an accepted request at cycle k occupies a fixed timeline.
   task automatic schedule(input int k, input logic [2:0] s, input logic [2:0] d);
      ev_t e;
      bit  clear_mode;
      clear_mode = 1'b0;
`ifdef MOV8_CLEAR_EN
      clear_mode = (s == d);
`endif
      for (int t = k + 1; t <= k + int'(S + L) + 2; t++) begin
         exp_busy[t] = 1'b1;
         if (t <= k + int'(S + L) + 1 && !clear_mode) exp_sel[t] = 8'b1 << s;
         if (t >= k + int'(S) + 1 && t <= k + int'(S + L)) exp_ld[t] = 8'b1 << d;
      end
      busy_until = k + int'(S + L) + 2;
      e.is_err = 1'b0; e.cyc = busy_until; e.s = s; e.d = d;
      sb.push_back(e);
   endtask

   // Drive one cycle of inputs and update the model.
   task automatic step(input bit st, input logic [2:0] s, input logic [2:0] d, input bit rst);
      int  c;
      ev_t e;
      @(negedge clk);
      c = edges + 1;
      reset = rst; start = st; src = s; dst = d;
      if (rst) begin
         for (int t = c + 1; t <= busy_until && t < N; t++) begin
            exp_sel[t] = '0; exp_ld[t] = '0; exp_busy[t] = 1'b0;
         end
         if (busy_until > c) busy_until = c;
         while (sb.size() > 0 && sb[$].cyc > c) void'(sb.pop_back());
      end else if (st && c > busy_until) begin
`ifdef MOV8_CLEAR_EN
         schedule(c, s, d);
`else
         if (s == d) begin
            e.is_err = 1'b1; e.cyc = c + 1; e.s = s; e.d = d;
            sb.push_back(e);
         end else begin
            schedule(c, s, d);
         end
`endif
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 3'd0, 3'd0, 1'b0);
   endtask

   // Monitor: per-cycle strobe compare plus scoreboard pop on done/err.
   always @(negedge clk) begin
      if (checking) begin
         mc = edges + 1;
         check("sel", mc, sel, exp_sel[mc]);
         check("ld", mc, ld, exp_ld[mc]);
         check("busy", mc, 8'(busy), 8'(exp_busy[mc]));
`ifndef MOV8_CLEAR_EN
         if (ld != '0) check("ld_without_prior_sel", mc, 8'(prev_sel != '0), 8'd1);
`endif
         prev_sel = sel;
         if (done === 1'b1 || err === 1'b1) begin
            vectors++;
            if (sb.size() == 0 || sb[0].cyc != mc || sb[0].is_err != (err === 1'b1)
                || (done === 1'b1 && err === 1'b1)) begin
               miscompares++;
               $display("FAIL pulse cycle %0d: got done=%b err=%b, expected event %s at cycle %0d",
                        mc, done, err, (sb.size() == 0) ? "none" : (sb[0].is_err ? "err" : "done"),
                        (sb.size() == 0) ? -1 : sb[0].cyc);
            end else begin
               void'(sb.pop_front());
            end
         end
         while (sb.size() > 0 && sb[0].cyc <= mc) begin
            vectors++;
            miscompares++;
            $display("FAIL missed_pulse: %s expected at cycle %0d, got none by cycle %0d",
                     sb[0].is_err ? "err" : "done", sb[0].cyc, mc);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         exp_sel[i] = '0; exp_ld[i] = '0; exp_busy[i] = 1'b0;
      end
      step(1'b0, 3'd0, 3'd0, 1'b1);
      checking = 1'b1;
      step(1'b0, 3'd0, 3'd0, 1'b1);
      idle(2);
      // A -> M2 basic transfer
      step(1'b1, 3'd0, 3'd5, 1'b0);
      idle(8);
      // X -> B with a start during the transfer (ignored)
      step(1'b1, 3'd6, 3'd1, 1'b0);
      step(1'b0, 3'd0, 3'd0, 1'b0);
      step(1'b1, 3'd3, 3'd4, 1'b0);
      idle(8);
      // Reset in the middle of an A -> M2 transfer, then restart
      step(1'b1, 3'd0, 3'd5, 1'b0);
      idle(2);
      step(1'b0, 3'd0, 3'd0, 1'b1);
      step(1'b1, 3'd0, 3'd5, 1'b0);
      idle(8);
      // src == dst request
      step(1'b1, 3'd2, 3'd2, 1'b0);
      idle(8);
      // Start in the DONE cycle is ignored; back-to-back at minimum spacing
      step(1'b1, 3'd1, 3'd7, 1'b0);
      idle(int'(S + L) + 1);
      step(1'b1, 3'd2, 3'd3, 1'b0);
      step(1'b1, 3'd4, 3'd6, 1'b0);
      idle(int'(S + L) + 2);
      step(1'b1, 3'd7, 3'd0, 1'b0);
      idle(8);
      // Randomized traffic
      for (int i = 0; i < 1200; i++) begin
         int unsigned r;
         logic [2:0]  s, d;
         r = $urandom_range(0, 99);
         s = 3'($urandom_range(0, 7));
         d = ($urandom_range(0, 5) == 0) ? s : 3'($urandom_range(0, 7));
         if (r < 2)       step(1'b0, s, d, 1'b1);
         else if (r < 45) step(1'b1, s, d, 1'b0);
         else             step(1'b0, s, d, 1'b0);
      end
      idle(12);
      @(negedge clk);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d outstanding events, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
